// File: rtl/spi_sort_bridge.sv
// Command bridge between a byte-wide SPI slave and a word-wide sorter.
// Handles multi-byte word writes and reads, a status readout, and occupancy tracking with sticky error flags.
module spi_sort_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic                  sort_enable,
  output logic                  sort_write,
  output logic [DATA_WIDTH-1:0] sort_unsorted_data,
  input  logic [DATA_WIDTH-1:0] sort_sorted_data,
  output logic [7:0]            count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST  = IW'(BYTES - 1);
  localparam logic [7:0]    SIZE8 = 8'(SIZE);

  typedef enum logic [2:0] {CMD, WR, RD, STAT, DISCARD} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] wr_sr, tx_sr;
  logic [1:0]            reload;
  logic                  stat_step, stat_seen;

  logic                  last, push_ok, push_ovf, pop_ok, pop_unf, op_load;
  logic [DATA_WIDTH-1:0] assembled, shifted, head;
  logic [7:0]            status;

  always_comb begin
    state_nxt = state;
    last      = rx_valid && (idx == LAST);
    push_ok   = (state == WR) && last && (count < SIZE8);
    push_ovf  = (state == WR) && last && !(count < SIZE8);
    pop_ok    = (state == RD) && last && (count != 8'd0);
    pop_unf   = (state == RD) && last && (count == 8'd0);
    op_load   = (state == CMD) && rx_valid && ((rx_byte == 8'h02) || (rx_byte == 8'h03));
    assembled = (wr_sr << 8) | DATA_WIDTH'(rx_byte);
    shifted   = tx_sr << 8;
    // An empty sorter's head is meaningless; present zeros instead.
    head      = (count == 8'd0) ? '0 : sort_sorted_data;
    status    = {(count == SIZE8), (count == 8'd0), overflow, underflow, 4'b0};
    if (state == CMD && rx_valid) begin
      case (rx_byte)
        8'h01:   state_nxt = WR;
        8'h02:   state_nxt = RD;
        8'h03:   state_nxt = STAT;
        default: state_nxt = DISCARD;
      endcase
    end
    if (!cs_active) state_nxt = CMD;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= CMD;
      idx                <= '0;
      wr_sr              <= '0;
      tx_sr              <= '0;
      reload             <= 2'd0;
      stat_step          <= 1'b0;
      stat_seen          <= 1'b0;
      tx_byte            <= 8'h00;
      sort_enable        <= 1'b0;
      sort_write         <= 1'b0;
      sort_unsorted_data <= '0;
      count              <= 8'd0;
      overflow           <= 1'b0;
      underflow          <= 1'b0;
    end else begin
      state       <= state_nxt;
      sort_enable <= push_ok || pop_ok;
      if (push_ok || pop_ok) sort_write <= push_ok;
      if (push_ok) sort_unsorted_data <= assembled;
      if (push_ok)     count <= count + 8'd1;
      else if (pop_ok) count <= count - 8'd1;
      if (push_ovf) overflow  <= 1'b1;
      if (pop_unf)  underflow <= 1'b1;

      if (rx_valid && (state == WR || state == RD))
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      if (rx_valid && state == WR) wr_sr <= assembled;

      // Head reload delay: one cycle after an opcode, two after a pop so
      // the sorter has settled its new head.
      if (op_load)           reload <= 2'd1;
      else if (pop_ok)       reload <= 2'd2;
      else if (reload != 0)  reload <= reload - 2'd1;

      if (state == CMD && rx_valid && rx_byte == 8'h03) begin
        stat_step <= 1'b0;
        stat_seen <= 1'b1;
      end

      if (state_nxt == CMD || state_nxt == WR) begin
        tx_byte <= 8'h00;
      end else if (state_nxt == DISCARD) begin
        tx_byte <= 8'hFF;
      end else if (state == RD) begin
        if (reload == 2'd1) begin
          tx_sr   <= head;
          tx_byte <= head[DATA_WIDTH-1 -: 8];
        end else if (pop_unf) begin
          tx_sr   <= '0;
          tx_byte <= 8'h00;
        end else if (rx_valid) begin
          tx_sr   <= shifted;
          tx_byte <= shifted[DATA_WIDTH-1 -: 8];
        end
      end else if (state == STAT) begin
        if (reload == 2'd1) begin
          tx_byte <= status;
        end else if (rx_valid) begin
          tx_byte   <= stat_step ? 8'h00 : count;
          stat_step <= 1'b1;
        end
      end

      if (!cs_active) begin
        idx    <= '0;
        wr_sr  <= '0;
        reload <= 2'd0;
        if (stat_seen) begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
          stat_seen <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_sort_bridge.sv
// Bench for spi_sort_bridge: behavioural sorter, queue-based reference model,
// directed scenarios followed by randomized transactions.
module tb_spi_sort_bridge;
  localparam int DW    = 16;
  localparam int SZ    = 4;
  localparam int BYTES = DW / 8;

  logic          clk = 0, reset = 0, cs_active = 0, rx_valid = 0;
  logic [7:0]    rx_byte = 0;
  logic [7:0]    tx_byte, count;
  logic          sort_enable, sort_write, overflow, underflow;
  logic [DW-1:0] sort_unsorted_data, sort_sorted_data;

  int total = 0, bad = 0;
  int n_push = 0, n_pop = 0;
  logic [DW-1:0] push_log[$];
  logic [DW-1:0] srt[$];
  int srt_k;
  logic prev_en = 0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pushes[$];
  bit m_ovf = 0, m_unf = 0;
  int m_npush = 0, m_npop = 0;

  always #5 clk = ~clk;

  spi_sort_bridge #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .reset(reset), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .sort_enable(sort_enable),
    .sort_write(sort_write), .sort_unsorted_data(sort_unsorted_data),
    .sort_sorted_data(sort_sorted_data), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Sorter stand-in: head valid the cycle after a strobe.
  always @(posedge clk) begin
    if (!reset) begin
      srt.delete();
      sort_sorted_data <= '0;
    end else begin
      if (sort_enable) begin
        if (sort_write) begin
          srt_k = 0;
          while (srt_k < srt.size() && srt[srt_k] <= sort_unsorted_data) srt_k++;
          srt.insert(srt_k, sort_unsorted_data);
        end else if (srt.size() > 0) begin
          void'(srt.pop_front());
        end
      end
      sort_sorted_data <= (srt.size() > 0) ? srt[0] : '0;
    end
  end

  always @(posedge clk) begin
    if (reset && sort_enable) begin
      if (sort_write) begin push_log.push_back(sort_unsorted_data); n_push++; end
      else n_pop++;
      total++;
      if (prev_en) begin
        bad++;
        $display("FAIL strobe_gap: sort_enable high two cycles in a row at %0t", $time);
      end
    end
    prev_en <= sort_enable;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int m_min_idx();
    int mi = 0;
    for (int i = 1; i < m_q.size(); i++) if (m_q[i] < m_q[mi]) mi = i;
    return mi;
  endfunction

  // Reference: expected tx byte seen before each data byte of one transaction.
  task automatic m_apply(input logic [7:0] op, input logic [7:0] d[$], output logic [7:0] ex[$]);
    logic [DW-1:0] acc, cur;
    logic [7:0] snap;
    int pos;
    ex = {};
    acc = '0;
    cur = '0;
    snap = {m_q.size() == SZ, m_q.size() == 0, m_ovf, m_unf, 4'b0};
    for (int i = 0; i < d.size(); i++) begin
      pos = i % BYTES;
      case (op)
        8'h01: begin
          ex.push_back(8'h00);
          acc = (acc << 8) | DW'(d[i]);
          if (pos == BYTES - 1) begin
            if (m_q.size() < SZ) begin
              m_q.push_back(acc); m_pushes.push_back(acc); m_npush++;
            end else m_ovf = 1;
          end
        end
        8'h02: begin
          if (pos == 0) cur = (m_q.size() > 0) ? m_q[m_min_idx()] : '0;
          ex.push_back(cur[DW-1-8*pos -: 8]);
          if (pos == BYTES - 1) begin
            if (m_q.size() > 0) begin m_q.delete(m_min_idx()); m_npop++; end
            else m_unf = 1;
          end
        end
        8'h03: ex.push_back(i == 0 ? snap : (i == 1 ? 8'(m_q.size()) : 8'h00));
        default: ex.push_back(8'hFF);
      endcase
    end
    if (op == 8'h03) begin m_ovf = 0; m_unf = 0; end
  endtask

  task automatic xfer(input logic [7:0] b, input bit drop, output logic [7:0] seen);
    @(negedge clk);
    seen = tx_byte;
    rx_byte = b;
    rx_valid = 1;
    if (drop) cs_active = 0;
    @(negedge clk);
    rx_valid = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_txn(input logic [7:0] op, input logic [7:0] d[$], input bit drop_last,
                        output logic [7:0] seen[$]);
    logic [7:0] s;
    seen = {};
    @(negedge clk); cs_active = 1;
    repeat (2) @(negedge clk);
    xfer(op, 0, s);
    for (int i = 0; i < d.size(); i++) begin
      xfer(d[i], drop_last && (i == d.size() - 1), s);
      seen.push_back(s);
    end
    @(negedge clk); cs_active = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] s;
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx: got %h want 00", tx_byte); end
    total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count: got %h want 00", count); end
    cs_active = 1;
    repeat (2) @(negedge clk);
    xfer(8'h01, 0, s);
    xfer(8'h12, 0, s);
    reset = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_byte, sort_enable, sort_write, overflow, underflow} !== 12'h000 ||
        sort_unsorted_data !== '0 || count !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_wr: tx=%h en=%b wr=%b data=%h cnt=%h ovf=%b unf=%b want all zero",
               tx_byte, sort_enable, sort_write, sort_unsorted_data, count, overflow, underflow);
    end
    total++; if (n_push !== 0) begin bad++; $display("FAIL reset_no_strobe: pushes=%0d want 0", n_push); end
    cs_active = 0;
    reset = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_push();
    logic [7:0] s, d[$], ex[$], seen[$];
    d = {8'h12, 8'h34};
    m_apply(8'h01, d, ex);
    @(negedge clk); cs_active = 1;
    repeat (2) @(negedge clk);
    xfer(8'h01, 0, s);
    xfer(8'h12, 0, s);
    @(negedge clk); rx_byte = 8'h34; rx_valid = 1;
    @(negedge clk); rx_valid = 0;
    total++;
    if (sort_enable !== 1'b1 || sort_write !== 1'b1 || sort_unsorted_data !== 16'h1234 || count !== 8'd1) begin
      bad++;
      $display("FAIL push_strobe: en=%b wr=%b data=%h cnt=%0d want 1 1 1234 1",
               sort_enable, sort_write, sort_unsorted_data, count);
    end
    @(negedge clk);
    total++; if (sort_enable !== 1'b0) begin bad++; $display("FAIL push_pulse_width: en=%b want 0", sort_enable); end
    repeat (6) @(negedge clk);
    cs_active = 0;
    repeat (3) @(negedge clk);
    d = {8'h00, 8'h00};
    m_apply(8'h02, d, ex);
    do_txn(8'h02, d, 0, seen);
    total++;
    if (seen[0] !== 8'h12 || seen[1] !== 8'h34) begin
      bad++; $display("FAIL push_readback: got %h %h want 12 34", seen[0], seen[1]);
    end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL push_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_sorted_read();
    logic [7:0] d[$], ex[$], seen[$];
    logic [7:0] want[6];
    int pops0;
    want = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    d = {8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
    m_apply(8'h01, d, ex);
    do_txn(8'h01, d, 0, seen);
    pops0 = n_pop;
    d = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    m_apply(8'h02, d, ex);
    do_txn(8'h02, d, 0, seen);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (seen[i] !== want[i]) begin bad++; $display("FAIL sorted_read[%0d]: got %h want %h", i, seen[i], want[i]); end
    end
    total++; if (n_pop - pops0 !== 3) begin bad++; $display("FAIL sorted_pops: got %0d want 3", n_pop - pops0); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL sorted_count: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    logic [7:0] d[$], ex[$], seen[$];
    int push0 = n_push;
    d = {};
    for (int i = 0; i < 5 * BYTES; i++) d.push_back(8'($urandom));
    m_apply(8'h01, d, ex);
    do_txn(8'h01, d, 0, seen);
    total++; if (n_push - push0 !== 4) begin bad++; $display("FAIL ovf_strobes: got %0d want 4", n_push - push0); end
    total++; if (count !== 8'd4 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_flags: cnt=%0d ovf=%b want 4 1", count, overflow); end
    d = {8'h00, 8'h00, 8'h00};
    m_apply(8'h03, d, ex);
    do_txn(8'h03, d, 0, seen);
    total++;
    if (seen[0] !== 8'hA0 || seen[1] !== 8'h04 || seen[2] !== 8'h00) begin
      bad++; $display("FAIL ovf_status: got %h %h %h want a0 04 00", seen[0], seen[1], seen[2]);
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: ovf=%b want 0", overflow); end
    d = {};
    for (int i = 0; i < 4 * BYTES; i++) d.push_back(8'h00);
    m_apply(8'h02, d, ex);
    do_txn(8'h02, d, 0, seen);
    for (int i = 0; i < d.size(); i++) begin
      total++;
      if (seen[i] !== ex[i]) begin bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, seen[i], ex[i]); end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] d[$], ex[$], seen[$];
    int ev0 = n_push + n_pop;
    d = {8'h5A, 8'hA5};
    m_apply(8'h02, d, ex);
    do_txn(8'h02, d, 0, seen);
    total++;
    if (seen[0] !== 8'h00 || seen[1] !== 8'h00) begin
      bad++; $display("FAIL unf_tx: got %h %h want 00 00", seen[0], seen[1]);
    end
    total++; if (n_push + n_pop !== ev0) begin bad++; $display("FAIL unf_no_strobe: strobes=%0d want 0", n_push + n_pop - ev0); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_flag: unf=%b want 1", underflow); end
    d = {8'h00};
    m_apply(8'h03, d, ex);
    do_txn(8'h03, d, 0, seen);
    total++; if (seen[0] !== 8'h50) begin bad++; $display("FAIL unf_status: got %h want 50", seen[0]); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear: unf=%b want 0", underflow); end
  endtask

  task automatic test_abort();
    logic [7:0] d[$], ex[$], seen[$];
    int push0 = n_push;
    d = {8'hAB};
    m_apply(8'h01, d, ex);
    do_txn(8'h01, d, 0, seen);
    total++; if (n_push !== push0) begin bad++; $display("FAIL abort_no_strobe: pushes=%0d want 0", n_push - push0); end
    d = {8'hCD, 8'hEF};
    m_apply(8'h01, d, ex);
    do_txn(8'h01, d, 0, seen);
    total++;
    if (n_push - push0 !== 1 || push_log[push_log.size()-1] !== 16'hCDEF) begin
      bad++; $display("FAIL abort_next_push: pushes=%0d last=%h want 1 cdef", n_push - push0, push_log[push_log.size()-1]);
    end
    d = {8'h11, 8'h22};
    m_apply(8'h7F, d, ex);
    do_txn(8'h7F, d, 0, seen);
    total++;
    if (seen[0] !== 8'hFF || seen[1] !== 8'hFF) begin
      bad++; $display("FAIL discard_tx: got %h %h want ff ff", seen[0], seen[1]);
    end
    d = {8'h55, 8'h66};
    m_apply(8'h01, d, ex);
    do_txn(8'h01, d, 1, seen);
    total++;
    if (push_log[push_log.size()-1] !== 16'h5566 || count !== 8'd2) begin
      bad++; $display("FAIL cs_drop_push: last=%h cnt=%0d want 5566 2", push_log[push_log.size()-1], count);
    end
    d = {8'h00, 8'h00, 8'h00, 8'h00};
    m_apply(8'h02, d, ex);
    do_txn(8'h02, d, 0, seen);
    total++;
    if ({seen[0], seen[1], seen[2], seen[3]} !== 32'h5566CDEF) begin
      bad++; $display("FAIL abort_drain: got %h%h%h%h want 5566cdef", seen[0], seen[1], seen[2], seen[3]);
    end
  endtask

  task automatic test_random();
    logic [7:0] op, d[$], ex[$], seen[$];
    int n;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = 8'h01;
        2:       op = 8'h02;
        3:       op = 8'h03;
        default: op = 8'($urandom);
      endcase
      n = $urandom_range(0, 7);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      m_apply(op, d, ex);
      do_txn(op, d, 0, seen);
      for (int i = 0; i < n; i++) begin
        total++;
        if (seen[i] !== ex[i]) begin
          bad++; $display("FAIL rand_tx t=%0d op=%h byte=%0d: got %h want %h", t, op, i, seen[i], ex[i]);
        end
      end
      total++;
      if (count !== 8'(m_q.size()) || overflow !== m_ovf || underflow !== m_unf) begin
        bad++; $display("FAIL rand_state t=%0d: cnt=%0d ovf=%b unf=%b want %0d %b %b",
                        t, count, overflow, underflow, m_q.size(), m_ovf, m_unf);
      end
    end
    total++;
    if (n_push !== m_npush || n_pop !== m_npop) begin
      bad++; $display("FAIL rand_strobes: push=%0d pop=%0d want %0d %0d", n_push, n_pop, m_npush, m_npop);
    end
    for (int i = 0; i < m_pushes.size() && i < push_log.size(); i++) begin
      total++;
      if (push_log[i] !== m_pushes[i]) begin
        bad++; $display("FAIL push_data[%0d]: got %h want %h", i, push_log[i], m_pushes[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_sorted_read();
    test_overflow();
    test_underflow();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
